// File: rtl/t07_flag_controller.sv
// -----------------------------------------------------------------------------
// t07_flag_controller
//
// Owns the 8x8 flag bitmap of the minesweeper board.
//   * Game-logic side: flag-toggle requests are serialised through a small FSM
//     (IDLE -> CHECK -> UPDATE). The FSM enforces the flag budget, refuses to
//     place a flag on a revealed cell and can wipe the board row by row (CLEAR).
//   * VGA side: a two-stage pipeline maps pixel (x,y) to a board cell and
//     reports whether that cell is flagged, for the flag sprite generator.
//
// Ports
//   clk           in   system clock, rising edge
//   nrst          in   asynchronous active-low reset
//   toggle_req    in   toggle request for (cur_x,cur_y), held until toggle_ack
//   cur_x/cur_y   in   cursor cell column / row
//   cur_revealed  in   reveal status of the cursor cell
//   clear_req     in   one-cycle pulse, clears every flag
//   toggle_ack    out  one-cycle completion pulse of a toggle
//   toggle_result out  01 placed, 10 removed, 11 rejected (valid with ack)
//   busy          out  FSM is not in IDLE
//   flag_count    out  number of flags currently set
//   flags_full    out  flag_count == MAX_FLAGS
//   x/y           in   pixel column / row
//   pix_in_board  out  pixel lies inside the board (2-cycle latency)
//   pix_flagged   out  pixel's cell holds a flag      (2-cycle latency)
//   pix_cell_x/y  out  cell column / row of the pixel (2-cycle latency)
// -----------------------------------------------------------------------------
module t07_flag_controller #(
  parameter int ORIGIN    = 18,
  parameter int CELL      = 36,
  parameter int MAX_FLAGS = 10
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       toggle_req,
  input  logic [2:0] cur_x,
  input  logic [2:0] cur_y,
  input  logic       cur_revealed,
  input  logic       clear_req,
  output logic       toggle_ack,
  output logic [1:0] toggle_result,
  output logic       busy,
  output logic [6:0] flag_count,
  output logic       flags_full,
  input  logic [8:0] x,
  input  logic [8:0] y,
  output logic       pix_in_board,
  output logic       pix_flagged,
  output logic [2:0] pix_cell_x,
  output logic [2:0] pix_cell_y
);

  localparam logic [6:0] MAX_CNT   = 7'(MAX_FLAGS);
  localparam logic [9:0] BOARD_LO  = 10'(ORIGIN);
  localparam logic [9:0] BOARD_HI  = 10'(ORIGIN + 8 * CELL);

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLACE  = 2'b01;
  localparam logic [1:0] RES_REMOVE = 2'b10;
  localparam logic [1:0] RES_REJECT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_CLEAR  = 2'd3
  } state_e;

  // Cell index along one axis by thermometer compare against the 7 inner
  // cell boundaries; pixels left of the board fold to 0, right of it to 7.
  function automatic logic [2:0] cell_index(input logic [8:0] p);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, p} >= 10'(ORIGIN + k * CELL)) begin
        idx = idx + 3'd1;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Half-open interval test of one pixel coordinate against the board span.
  function automatic logic on_board(input logic [8:0] p);
    return ({1'b0, p} >= BOARD_LO) && ({1'b0, p} < BOARD_HI);
  endfunction

  // FSM and bitmap state. Bitmap bit index = {row, col}.
  state_e      state_q,    state_d;
  logic [63:0] bitmap_q,   bitmap_d;
  logic [6:0]  count_q,    count_d;
  logic [2:0]  clr_row_q,  clr_row_d;
  logic [2:0]  lat_x_q,    lat_x_d;
  logic [2:0]  lat_y_q,    lat_y_d;
  logic        lat_rev_q,  lat_rev_d;
  logic        lat_bit_q,  lat_bit_d;
  logic [1:0]  res_q,      res_d;
  logic        ack_q,      ack_d;

  // Pixel pipeline registers.
  logic [2:0]  s1_col_q,   s1_row_q;
  logic        s1_inb_q;
  logic [2:0]  s2_col_q,   s2_row_q;
  logic        s2_inb_q,   s2_flag_q;

  logic [5:0]  lat_idx_s;
  assign lat_idx_s = {lat_y_q, lat_x_q};

  // FSM next-state, bitmap/count update and ack/result generation.
  always_comb begin
    state_d   = state_q;
    bitmap_d  = bitmap_q;
    count_d   = count_q;
    clr_row_d = clr_row_q;
    lat_x_d   = lat_x_q;
    lat_y_d   = lat_y_q;
    lat_rev_d = lat_rev_q;
    lat_bit_d = lat_bit_q;
    res_d     = RES_NONE;
    ack_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Clear has priority; a simultaneous toggle stays pending on the
        // held toggle_req and is picked up once the clear finishes.
        if (clear_req) begin
          clr_row_d = 3'd0;
          state_d   = ST_CLEAR;
        end else if (toggle_req) begin
          lat_x_d   = cur_x;
          lat_y_d   = cur_y;
          lat_rev_d = cur_revealed;
          lat_bit_d = bitmap_q[{cur_y, cur_x}];
          state_d   = ST_CHECK;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_CHECK: begin
        // Result and ack are registered here so they appear in UPDATE.
        ack_d   = 1'b1;
        state_d = ST_UPDATE;
        if (lat_bit_q) begin
          res_d = RES_REMOVE;
        end else if (lat_rev_q) begin
          res_d = RES_REJECT;
        end else if (count_q >= MAX_CNT) begin
          res_d = RES_REJECT;
        end else begin
          res_d = RES_PLACE;
        end
      end

      ST_UPDATE: begin
        state_d = ST_IDLE;
        case (res_q)
          RES_PLACE: begin
            // Guard keeps the count inside the budget even if res_q were corrupted.
            if (count_q < MAX_CNT) begin
              bitmap_d[lat_idx_s] = 1'b1;
              count_d             = count_q + 7'd1;
            end else begin
              count_d = count_q;
            end
          end
          RES_REMOVE: begin
            if (count_q != 7'd0) begin
              bitmap_d[lat_idx_s] = 1'b0;
              count_d             = count_q - 7'd1;
            end else begin
              count_d = count_q;
            end
          end
          default: begin
            count_d = count_q;
          end
        endcase
      end

      ST_CLEAR: begin
        bitmap_d[{clr_row_q, 3'b000} +: 8] = 8'h00;
        if (clr_row_q == 3'd7) begin
          count_d   = 7'd0;
          clr_row_d = 3'd0;
          state_d   = ST_IDLE;
        end else begin
          clr_row_d = clr_row_q + 3'd1;
          state_d   = ST_CLEAR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, bitmap and toggle-handshake registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      bitmap_q  <= 64'd0;
      count_q   <= 7'd0;
      clr_row_q <= 3'd0;
      lat_x_q   <= 3'd0;
      lat_y_q   <= 3'd0;
      lat_rev_q <= 1'b0;
      lat_bit_q <= 1'b0;
      res_q     <= RES_NONE;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitmap_q  <= bitmap_d;
      count_q   <= count_d;
      clr_row_q <= clr_row_d;
      lat_x_q   <= lat_x_d;
      lat_y_q   <= lat_y_d;
      lat_rev_q <= lat_rev_d;
      lat_bit_q <= lat_bit_d;
      res_q     <= res_d;
      ack_q     <= ack_d;
    end
  end

  // Pixel stage 1: coordinate-to-cell mapping and board window test.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_col_q <= 3'd0;
      s1_row_q <= 3'd0;
      s1_inb_q <= 1'b0;
    end else begin
      s1_col_q <= cell_index(x);
      s1_row_q <= cell_index(y);
      s1_inb_q <= on_board(x) && on_board(y);
    end
  end

  // Pixel stage 2: bitmap lookup. Reads bitmap_q, i.e. the value before any
  // write landing on the same edge; a half-cleared board may show briefly.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s2_col_q  <= 3'd0;
      s2_row_q  <= 3'd0;
      s2_inb_q  <= 1'b0;
      s2_flag_q <= 1'b0;
    end else begin
      s2_col_q  <= s1_col_q;
      s2_row_q  <= s1_row_q;
      s2_inb_q  <= s1_inb_q;
      s2_flag_q <= s1_inb_q && bitmap_q[{s1_row_q, s1_col_q}];
    end
  end

  assign toggle_ack    = ack_q;
  assign toggle_result = res_q;
  assign busy          = (state_q != ST_IDLE);
  assign flag_count    = count_q;
  assign flags_full    = (count_q == MAX_CNT);
  assign pix_in_board  = s2_inb_q;
  assign pix_flagged   = s2_flag_q;
  assign pix_cell_x    = s2_col_q;
  assign pix_cell_y    = s2_row_q;

endmodule

// File: tb/tb_t07_flag_controller.sv
// -----------------------------------------------------------------------------
// Testbench for t07_flag_controller: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// behavioural model that tracks the board as an 8x8 array and a busy countdown.
// -----------------------------------------------------------------------------
module tb_t07_flag_controller;

  localparam int ORIGIN = 18;
  localparam int CELL   = 36;
  localparam int MAXF   = 10;

  logic       clk          = 1'b0;
  logic       nrst         = 1'b0;
  logic       toggle_req   = 1'b0;
  logic [2:0] cur_x        = 3'd0;
  logic [2:0] cur_y        = 3'd0;
  logic       cur_revealed = 1'b0;
  logic       clear_req    = 1'b0;
  logic [8:0] x            = 9'd0;
  logic [8:0] y            = 9'd0;
  logic       toggle_ack;
  logic [1:0] toggle_result;
  logic       busy;
  logic [6:0] flag_count;
  logic       flags_full;
  logic       pix_in_board;
  logic       pix_flagged;
  logic [2:0] pix_cell_x;
  logic [2:0] pix_cell_y;

  t07_flag_controller #(.ORIGIN(ORIGIN), .CELL(CELL), .MAX_FLAGS(MAXF)) dut (
    .clk(clk), .nrst(nrst), .toggle_req(toggle_req), .cur_x(cur_x), .cur_y(cur_y),
    .cur_revealed(cur_revealed), .clear_req(clear_req), .toggle_ack(toggle_ack),
    .toggle_result(toggle_result), .busy(busy), .flag_count(flag_count),
    .flags_full(flags_full), .x(x), .y(y), .pix_in_board(pix_in_board),
    .pix_flagged(pix_flagged), .pix_cell_x(pix_cell_x), .pix_cell_y(pix_cell_y)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en   = 1'b0;
  bit rand_pix = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_bm [8][8];
  int m_count, m_left, m_res, m_tx, m_ty;
  bit m_is_clr;
  int p1_col, p1_row, p2_col, p2_row;
  bit p1_in, p2_in, p2_flag;

  function automatic int cell_of(input int p);
    if (p < ORIGIN) return 0;
    else if ((p - ORIGIN) / CELL > 7) return 7;
    else return (p - ORIGIN) / CELL;
  endfunction

  function automatic bit inside_board(input int p);
    return (p >= ORIGIN) && (p < ORIGIN + 8 * CELL);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) m_bm[r][c] = 1'b0;
    m_count = 0; m_left = 0; m_res = 0; m_tx = 0; m_ty = 0; m_is_clr = 1'b0;
    p1_col = 0; p1_row = 0; p1_in = 1'b0;
    p2_col = 0; p2_row = 0; p2_in = 1'b0; p2_flag = 1'b0;
  endtask

  // m_left = busy cycles left including the current one (0 means idle).
  task automatic model_step();
    p2_flag = p1_in && m_bm[p1_row][p1_col];
    p2_col  = p1_col; p2_row = p1_row; p2_in = p1_in;
    p1_col  = cell_of(int'(x));
    p1_row  = cell_of(int'(y));
    p1_in   = inside_board(int'(x)) && inside_board(int'(y));
    if (m_left == 0) begin
      if (clear_req) begin
        m_is_clr = 1'b1; m_left = 8;
      end else if (toggle_req) begin
        m_is_clr = 1'b0; m_left = 2; m_tx = int'(cur_x); m_ty = int'(cur_y);
        if (m_bm[m_ty][m_tx]) m_res = 2;
        else if (cur_revealed || m_count == MAXF) m_res = 3;
        else m_res = 1;
      end
    end else begin
      if (m_is_clr) begin
        for (int c = 0; c < 8; c++) m_bm[8 - m_left][c] = 1'b0;
        if (m_left == 1) m_count = 0;
      end else if (m_left == 1) begin
        if (m_res == 1) begin m_bm[m_ty][m_tx] = 1'b1; m_count++; end
        else if (m_res == 2) begin m_bm[m_ty][m_tx] = 1'b0; m_count--; end
      end
      m_left--;
    end
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) model_reset();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (nrst && cmp_en) begin
        check("busy",      int'(busy),          int'(m_left > 0));
        check("ack",       int'(toggle_ack),    int'(!m_is_clr && m_left == 1));
        check("result",    int'(toggle_result), (!m_is_clr && m_left == 1) ? m_res : 0);
        check("count",     int'(flag_count),    m_count);
        check("full",      int'(flags_full),    int'(m_count == MAXF));
        check("in_board",  int'(pix_in_board),  int'(p2_in));
        check("flagged",   int'(pix_flagged),   int'(p2_flag));
        check("cell_x",    int'(pix_cell_x),    p2_col);
        check("cell_y",    int'(pix_cell_y),    p2_row);
      end
    end
  end

  // Random pixel traffic while enabled.
  initial begin : pix_drv
    forever begin
      @(posedge clk); #1;
      if (rand_pix) begin
        x = 9'($urandom_range(0, 330));
        y = 9'($urandom_range(0, 330));
      end
    end
  end

  // ---------------- stimulus helpers (all start/end at posedge+1) ----------------
  task automatic do_toggle(input logic [2:0] cx, input logic [2:0] cy, input logic rev,
                           input logic with_clear, input logic noise,
                           output int res, output int cyc);
    bit got;
    got = 1'b0; res = -1; cyc = -1;
    cur_x = cx; cur_y = cy; cur_revealed = rev; toggle_req = 1'b1; clear_req = with_clear;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (toggle_ack) begin got = 1'b1; res = int'(toggle_result); cyc = i; end
      @(posedge clk); #1;
      clear_req = noise && !got && ($urandom_range(0, 7) == 0);
    end
    toggle_req = 1'b0; clear_req = 1'b0;
    if (!got) check("ack_timeout", 0, 1);
  endtask

  task automatic clear_pulse();
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix_probe(input string name, input int px, input int py, input int e_in,
                           input int e_fl, input int e_cx, input int e_cy, input bit cells);
    x = 9'(px); y = 9'(py);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({name, "_in"}, int'(pix_in_board), e_in);
    check({name, "_fl"}, int'(pix_flagged), e_fl);
    if (cells) begin
      check({name, "_cx"}, int'(pix_cell_x), e_cx);
      check({name, "_cy"}, int'(pix_cell_y), e_cy);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ack"},  int'(toggle_ack), 0);
    check({name, "_res"},  int'(toggle_result), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_cnt"},  int'(flag_count), 0);
    check({name, "_full"}, int'(flags_full), 0);
    check({name, "_inb"},  int'(pix_in_board), 0);
    check({name, "_flg"},  int'(pix_flagged), 0);
    check({name, "_cx"},   int'(pix_cell_x), 0);
    check({name, "_cy"},   int'(pix_cell_y), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int res, cyc;
    int xs [6] = '{17, 18, 53, 54, 305, 306};
    int ins[6] = '{0, 1, 1, 1, 1, 0};
    int cols[6] = '{0, 0, 0, 1, 7, 7};

    x = 9'd100; y = 9'd100;
    wait_cycles(3);
    check_all_zero("reset");
    nrst = 1'b1;
    cmp_en = 1'b1;
    wait_cycles(2);

    // Place, probe, remove, probe.
    do_toggle(3'd2, 3'd3, 1'b0, 1'b0, 1'b0, res, cyc);
    check("t1_res", res, 1);
    check("t1_lat", cyc, 2);
    check("t1_cnt", int'(flag_count), 1);
    pix_probe("t1_pix", 95, 131, 1, 1, 2, 3, 1'b1);
    do_toggle(3'd2, 3'd3, 1'b0, 1'b0, 1'b0, res, cyc);
    check("t2_res", res, 2);
    check("t2_cnt", int'(flag_count), 0);
    pix_probe("t2_pix", 95, 131, 1, 0, 2, 3, 1'b1);

    // Revealed cell is refused.
    do_toggle(3'd4, 3'd4, 1'b1, 1'b0, 1'b0, res, cyc);
    check("t3_res", res, 3);
    check("t3_cnt", int'(flag_count), 0);
    pix_probe("t3_pix", 167, 167, 1, 0, 4, 4, 1'b1);

    // Fill the budget, overflow attempt, then remove one.
    for (int i = 0; i < 10; i++) begin
      do_toggle(3'(i % 8), 3'(i / 8), 1'b0, 1'b0, 1'b0, res, cyc);
      check("t4_place", res, 1);
    end
    check("t4_cnt", int'(flag_count), 10);
    check("t4_full", int'(flags_full), 1);
    do_toggle(3'd7, 3'd7, 1'b0, 1'b0, 1'b0, res, cyc);
    check("t4_over_res", res, 3);
    check("t4_over_cnt", int'(flag_count), 10);
    check("t4_over_full", int'(flags_full), 1);
    do_toggle(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, res, cyc);
    check("t4_rm_res", res, 2);
    check("t4_rm_cnt", int'(flag_count), 9);
    check("t4_rm_full", int'(flags_full), 0);

    // Clear, then clear+toggle together: toggle serviced after the 8-cycle clear.
    clear_pulse();
    wait_cycles(9);
    check("t5_clr_cnt", int'(flag_count), 0);
    do_toggle(3'd1, 3'd1, 1'b0, 1'b0, 1'b0, res, cyc);
    do_toggle(3'd2, 3'd2, 1'b0, 1'b0, 1'b0, res, cyc);
    do_toggle(3'd3, 3'd3, 1'b0, 1'b0, 1'b0, res, cyc);
    check("t5_pre_cnt", int'(flag_count), 3);
    do_toggle(3'd5, 3'd5, 1'b0, 1'b1, 1'b0, res, cyc);
    check("t5_res", res, 1);
    check("t5_lat", cyc, 11);
    check("t5_cnt", int'(flag_count), 1);

    // Board edge sweep along row 0.
    for (int i = 0; i < 6; i++) begin
      pix_probe($sformatf("sweep%0d", xs[i]), xs[i], 20, ins[i], 0, cols[i], 0, ins[i] == 1);
    end

    // Reset during CLEAR.
    do_toggle(3'd6, 3'd0, 1'b0, 1'b0, 1'b0, res, cyc);
    clear_pulse();
    wait_cycles(3);
    nrst = 1'b0;
    #1;
    check_all_zero("rst_clr");
    wait_cycles(2);
    nrst = 1'b1;
    wait_cycles(2);

    // Reset during CHECK.
    do_toggle(3'd5, 3'd5, 1'b0, 1'b0, 1'b0, res, cyc);
    check("t7_pre_cnt", int'(flag_count), 1);
    cur_x = 3'd6; cur_y = 3'd6; cur_revealed = 1'b0; toggle_req = 1'b1;
    @(posedge clk); #1;
    check("t7_chk_busy", int'(busy), 1);
    nrst = 1'b0;
    toggle_req = 1'b0;
    #1;
    check_all_zero("rst_chk");
    wait_cycles(2);
    nrst = 1'b1;
    wait_cycles(4);
    pix_probe("t7_pix", 203, 203, 1, 0, 5, 5, 1'b1);

    // Randomized traffic checked by the model every cycle.
    rand_pix = 1'b1;
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 7) begin
        do_toggle(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) == 0), 1'b0, 1'b1, res, cyc);
      end else if (op < 8) begin
        clear_pulse();
      end else if (op < 9) begin
        do_toggle(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 1'b1, 1'b0, res, cyc);
      end else begin
        wait_cycles($urandom_range(1, 6));
      end
    end
    rand_pix = 1'b0;
    wait_cycles(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
